// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  typedef struct packed {
    logic [3:0] nbits;
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;
  } uart_frame_cfg_t;

  localparam int CFG_W = $bits(uart_frame_cfg_t);

  function automatic int clocks_per_baud(input int sysclk, input int baud);
    return sysclk / baud;
  endfunction

  // Anything outside 5..max_bits falls back to the full data width.
  function automatic logic [3:0] clamp_nbits(input logic [3:0] nbits, input int max_bits);
    if (int'(nbits) < 5 || int'(nbits) > max_bits) return 4'(max_bits);
    return nbits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO; a write is taken when full if a read happens in the same cycle.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          wr_ok, rd_ok;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign rd_ok   = i_rd && !o_empty;
  assign wr_ok   = i_wr && (!o_full || rd_ok);
  assign o_rdata = mem[rp_q];

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wp_q] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_ok) wp_q <= wp_q + 1'b1;
      if (rd_ok) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (5..9 data bits, optional parity, 1/2 stop bits).
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the shifter.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int SYSCLOCK   = 12000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic [3:0]           i_nbits,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  input  logic                 i_two_stop,
  output logic                 o_busy,
  output logic                 o_idle,
  output logic                 o_uart_tx
);
  localparam int CPB = clocks_per_baud(SYSCLOCK, BAUDRATE);
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;

  generate
    if (CPB < 2) begin : g_bad_baud
      $error("uart_tx_cfg: SYSCLOCK/BAUDRATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
  endgenerate

  tx_state_e             state_q, state_d;
  uart_frame_cfg_t       wr_cfg, ld_cfg, cfg_q;
  logic [DATA_BITS-1:0]  ld_data, sh_q;
  logic [CW-1:0]         cnt_q;
  logic [3:0]            bit_cnt_q;
  logic                  par_q, stop2_q, tick, load, start_req, tx_d;

  always_comb begin
    wr_cfg.nbits      = clamp_nbits(i_nbits, DATA_BITS);
    wr_cfg.parity_en  = i_parity_en;
    wr_cfg.parity_odd = i_parity_odd;
    wr_cfg.two_stop   = i_two_stop;
  end

`ifdef UART_TX_FIFO_EN
  localparam bit CHAIN = 1'b1;
  logic fifo_empty, fifo_full;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2 >= 2");
    end
  endgenerate

  uart_tx_fifo #(.W(CFG_W + DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (i_wr),
    .i_wdata ({wr_cfg, i_data}),
    .i_rd    (load),
    .o_rdata ({ld_cfg, ld_data}),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign start_req = !fifo_empty;
  assign o_busy    = fifo_full;
`else
  // Without the FIFO the shifter registers are the holding register.
  localparam bit CHAIN = 1'b0;

  generate
    if (FIFO_DEPTH < 0) begin : g_depth_unused
    end
  endgenerate

  assign start_req = i_wr;
  assign ld_cfg    = wr_cfg;
  assign ld_data   = i_data;
  assign o_busy    = (state_q != IDLE);
`endif

  assign tick = (cnt_q == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE:   if (start_req) begin
                load    = 1'b1;
                state_d = START;
              end
      START:  if (tick) state_d = DATA;
      DATA:   if (tick && bit_cnt_q == cfg_q.nbits - 4'd1)
                state_d = cfg_q.parity_en ? PARITY : STOP;
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick && (stop2_q || !cfg_q.two_stop)) begin
                if (CHAIN && start_req) begin
                  load    = 1'b1;
                  state_d = START;
                end else begin
                  state_d = IDLE;
                end
              end
      default: state_d = IDLE;
    endcase
  end

  // Line value for the bit that begins (or continues) after this edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = (state_q == DATA && tick) ? sh_q[1] : sh_q[0];
      PARITY:  tx_d = cfg_q.parity_odd ^ ((state_q == DATA) ? (par_q ^ sh_q[0]) : par_q);
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_uart_tx <= 1'b1;
      o_idle    <= 1'b1;
    end else begin
      o_uart_tx <= tx_d;
      o_idle    <= (state_q == IDLE) && !start_req;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      sh_q      <= '0;
      cfg_q     <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      stop2_q   <= 1'b0;
    end else if (load) begin
      cnt_q     <= CW'(CPB - 1);
      sh_q      <= ld_data;
      cfg_q     <= ld_cfg;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      stop2_q   <= 1'b0;
    end else begin
      if (state_q != IDLE) cnt_q <= tick ? CW'(CPB - 1) : cnt_q - 1'b1;
      if (state_q == DATA && tick) begin
        sh_q      <= sh_q >> 1;
        par_q     <= par_q ^ sh_q[0];
        bit_cnt_q <= bit_cnt_q + 4'd1;
      end
      if (state_q == STOP && tick) stop2_q <= 1'b1;
    end
  end

endmodule
